// File: rtl/shift_add_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_pkg : shared types and defaults for the shift-add multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shift_add_multiplier_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage : shift_add_multiplier_pkg

`default_nettype wire

// File: rtl/shift_add_datapath.sv
// ---------------------------------------------------------------------------
// shift_add_datapath : A/Q/B registers with the add-then-shift iteration
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_add_datapath
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  output logic [2*WIDTH-1:0]   result_o
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] step_a_w;
  logic [WIDTH-1:0] step_q_w;

  // The carry bit of A lives only in the sum: the right shift always clears it again.
  assign sum_w    = q_q[0] ? ({1'b0, a_q} + {1'b0, b_q}) : {1'b0, a_q};
  assign step_a_w = sum_w[WIDTH:1];
  assign step_q_w = {sum_w[0], q_q[WIDTH-1:1]};

  // Value of {A, Q} after the iteration happening on this edge.
  assign result_o = {step_a_w, step_q_w};

  always_comb begin
    a_d = a_q;
    q_d = q_q;
    b_d = b_q;
    if (load_i) begin
      a_d = '0;
      q_d = multiplier_i;
      b_d = multiplicand_i;
    end else if (step_i) begin
      a_d = step_a_w;
      q_d = step_q_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      q_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      q_q <= q_d;
      b_q <= b_d;
    end
  end

endmodule : shift_add_datapath

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier : radix-2 sequential unsigned multiplier, WIDTH cycles per product
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic                 start,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ready
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_e               state_q;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q;
  logic                 ready_q;
  logic                 load_w;
  logic                 step_w;
  logic [2*WIDTH-1:0]   dp_result_w;

  assign load_w  = (state_q == ST_IDLE) && start;
  assign step_w  = (state_q == ST_BUSY);
  assign count_d = count_q + CW'(1);

  shift_add_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk            (clk),
    .rst            (rst),
    .load_i         (load_w),
    .step_i         (step_w),
    .multiplier_i   (multiplier),
    .multiplicand_i (multiplicand),
    .result_o       (dp_result_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_BUSY;
            count_q <= '0;
            ready_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          count_q <= count_d;
          // Last iteration: publish the fully shifted {A, Q} in the same edge.
          if (count_q == LAST_CNT) begin
            product_q <= dp_result_w;
            ready_q   <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign product = product_q;
  assign ready   = ready_q;

endmodule : shift_add_multiplier

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier : scoreboard bench, random and directed multiplies
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shift_add_multiplier;

  localparam int W = 16;

  logic             clk;
  logic             rst;
  logic [W-1:0]     multiplier;
  logic [W-1:0]     multiplicand;
  logic             start;
  logic [2*W-1:0]   product;
  logic             ready;

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [2*W-1:0]   exp_q[$];
  int               left = 0;   // edges remaining until the model's operation completes

  shift_add_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .start        (start),
    .product      (product),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model accepts whenever it is idle and start is high.
  task automatic cyc(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb;
    start        = s;
    multiplier   = a;
    multiplicand = b;
    @(posedge clk);
    if (!rst) begin
      if (left == 0) begin
        if (s) begin
          ea = {{W{1'b0}}, a};
          eb = {{W{1'b0}}, b};
          exp_q.push_back(ea * eb);
          left = W;
        end
      end else begin
        left--;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, W'($urandom), W'($urandom));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    cyc(1'b1, a, b);
    idle(W + 2);
  endtask

  // Monitor: checks ready against the model timing and pops on every completion.
  initial begin : monitor
    bit             prev_ready;
    int             cnt;
    logic [2*W-1:0] hold;
    logic [2*W-1:0] e;
    prev_ready = 1'b1;
    cnt        = 0;
    hold       = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_ready = 1'b1;
        cnt        = 0;
        hold       = '0;
      end else begin
        check("ready", {63'd0, ready}, {63'd0, (left == 0)});
        if (prev_ready && !ready) cnt = 0;
        else if (!prev_ready) cnt++;
        if (!prev_ready && ready) begin
          check("latency", 64'(cnt), 64'(W));
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: completion with no expected result at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("product", 64'(product), 64'(e));
            hold = e;
          end
        end else begin
          check("product_hold", 64'(product), 64'(hold));
        end
        prev_ready = ready;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [W-1:0] ra, rb;
    rst          = 1'b1;
    start        = 1'b0;
    multiplier   = '0;
    multiplicand = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", {63'd0, ready}, 64'd1);
    check("reset_product", 64'(product), 64'd0);
    rst = 1'b0;

    idle(20);
    check("idle_product", 64'(product), 64'd0);

    run_op(16'd12, 16'd4);
    check("basic_48", 64'(product), 64'h30);

    run_op(16'hFFFF, 16'hFFFF);
    check("max_x_max", 64'(product), 64'hFFFE0001);
    run_op(16'h0000, 16'hABCD);
    check("zero_x", 64'(product), 64'd0);
    run_op(16'h0001, 16'h8000);
    check("one_x", 64'(product), 64'h8000);

    // start held high, operands switched mid-operation
    for (int i = 0; i < 8; i++)  cyc(1'b1, 16'd12, 16'd4);
    for (int i = 0; i < 25; i++) cyc(1'b1, 16'd3, 16'd5);
    idle(W + 2);
    check("b2b_second", 64'(product), 64'd15);

    // start and operand noise while busy
    cyc(1'b1, 16'd300, 16'd211);
    for (int i = 0; i < W - 1; i++) cyc(1'($urandom), W'($urandom), W'($urandom));
    idle(2);
    check("isolated", 64'(product), 64'd63300);

    // asynchronous reset part-way through an operation
    cyc(1'b1, 16'h1234, 16'h5678);
    idle(7);
    #2 rst = 1'b1;
    #1;
    check("midreset_ready", {63'd0, ready}, 64'd1);
    check("midreset_product", 64'(product), 64'd0);
    exp_q.delete();
    left = 0;
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h1234, 16'h5678);
    check("after_reset", 64'(product), 64'h06260060);

    for (int t = 0; t < 25; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (t % 5 == 0) ra = '1;
      if (t % 7 == 0) rb = '1;
      cyc(1'b1, ra, rb);
      for (int i = 0; i < W + 4; i++) cyc(1'($urandom_range(0, 3) == 0), W'($urandom), W'($urandom));
      idle(W + 2);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_shift_add_multiplier

`default_nettype wire
